// File: rtl/jpeg_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_frame_ctrl
// Brief    : Per-frame sequencer around jpeg_core: gates source words into the
//            core inport, counts decoded pixels and reports done / error.
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_frame_ctrl #(
  parameter int                   WORD_CNT_W  = 20,
  parameter int                   TIMEOUT_W   = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 24'hFFFFFF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [WORD_CNT_W-1:0] word_count_i,
  input  logic [3:0]            last_strb_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [31:0]           pixel_count_o,
  input  logic                  src_valid_i,
  input  logic [31:0]           src_data_i,
  output logic                  src_ready_o,
  output logic                  core_valid_o,
  output logic [31:0]           core_data_o,
  output logic [3:0]            core_strb_o,
  output logic                  core_last_o,
  input  logic                  core_accept_i,
  input  logic                  pix_valid_i,
  input  logic [15:0]           pix_width_i,
  input  logic [15:0]           pix_height_i,
  input  logic                  sink_ready_i,
  output logic                  pix_accept_o,
  input  logic                  core_idle_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [WORD_CNT_W-1:0] r_words_left;
  logic [3:0]            r_last_strb;
  logic [31:0]           r_pixel_count;
  logic [31:0]           r_target;
  logic                  r_target_v;
  logic [TIMEOUT_W-1:0]  r_timer;
  logic                  r_error;

  logic w_feed;
  logic w_drain;
  logic w_last;
  logic w_word_hs;
  logic w_pix_hs;
  logic w_cnt_hs;
  logic w_first_pix;
  logic w_dim_zero;
  logic w_start_ok;
  logic w_start_go;

  assign w_feed      = (r_state == S_FEED);
  assign w_drain     = (r_state == S_DRAIN);
  assign w_last      = (r_words_left == WORD_CNT_W'(1));
  assign w_word_hs   = w_feed & src_valid_i & core_accept_i;
  assign w_pix_hs    = pix_valid_i & sink_ready_i;
  assign w_cnt_hs    = (w_feed | w_drain) & w_pix_hs;
  assign w_first_pix = w_cnt_hs & ~r_target_v;
  assign w_dim_zero  = (pix_width_i == 16'd0) | (pix_height_i == 16'd0);
  assign w_start_ok  = start_i & ((r_state == S_IDLE) | (r_state == S_ERR));
  assign w_start_go  = w_start_ok & (word_count_i != '0);

  assign busy_o        = w_feed | w_drain;
  assign done_o        = (r_state == S_DONE);
  assign error_o       = r_error;
  assign pixel_count_o = r_pixel_count;
  assign pix_accept_o  = sink_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_error <= (w_next == S_ERR);
    end
  end

  always_comb begin
    w_next       = r_state;
    core_valid_o = 1'b0;
    src_ready_o  = 1'b0;
    core_data_o  = 32'd0;
    core_strb_o  = 4'd0;
    core_last_o  = 1'b0;
    case (r_state)
      S_IDLE, S_ERR: begin
        if (start_i) begin
          w_next = (word_count_i == '0) ? S_ERR : S_FEED;
        end
      end
      S_FEED: begin
        core_valid_o = src_valid_i;
        src_ready_o  = core_accept_i;
        core_data_o  = src_data_i;
        core_last_o  = w_last;
        core_strb_o  = w_last ? r_last_strb : 4'hF;
        if (w_first_pix & w_dim_zero) begin
          w_next = S_ERR;
        end else if (w_word_hs & w_last) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Completion uses the registered count, so it lands a cycle after the final pixel.
        if (w_first_pix & w_dim_zero) begin
          w_next = S_ERR;
        end else if (r_timer == TIMEOUT_CYC) begin
          w_next = S_ERR;
        end else if (r_target_v & (r_pixel_count > r_target)) begin
          w_next = S_ERR;
        end else if (r_target_v & (r_pixel_count == r_target) & core_idle_i) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_words_left  <= '0;
      r_last_strb   <= 4'd0;
      r_pixel_count <= 32'd0;
      r_target      <= 32'd0;
      r_target_v    <= 1'b0;
      r_timer       <= '0;
    end else if (w_start_go) begin
      r_words_left  <= word_count_i;
      r_last_strb   <= last_strb_i;
      r_pixel_count <= 32'd0;
      r_target      <= 32'd0;
      r_target_v    <= 1'b0;
      r_timer       <= '0;
    end else begin
      if (w_word_hs) begin
        r_words_left <= r_words_left - WORD_CNT_W'(1);
      end
      if (w_cnt_hs && (r_pixel_count != 32'hFFFF_FFFF)) begin
        r_pixel_count <= r_pixel_count + 32'd1;
      end
      if (w_first_pix) begin
        r_target   <= 32'(pix_width_i) * 32'(pix_height_i);
        r_target_v <= 1'b1;
      end
      // Watchdog only runs while waiting for the core to drain.
      if (w_drain && !w_pix_hs) begin
        r_timer <= r_timer + TIMEOUT_W'(1);
      end else begin
        r_timer <= '0;
      end
    end
  end

endmodule
`default_nettype wire
